// File: rtl/regwrite_trace_pkg.sv
// regwrite_trace_pkg
// Shared constants and the trace record layout for the register-write trace
// buffer. The default widths here match the top-level parameter defaults.
package regwrite_trace_pkg;

  localparam int DEF_DEPTH  = 8;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_SEQ_W  = 16;

  // One register-update record at the default widths.
  typedef struct packed {
    logic [DEF_SEQ_W-1:0]  seq;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } traceRec_t;

endpackage

// File: rtl/regwrite_trace_fifo.sv
// trace_fifo
// Synchronous first-word-fall-through FIFO. The head entry is visible on dout
// whenever the FIFO is non-empty; dout reads as zero when empty so the
// downstream record fields are clean after reset.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   push, din       enqueue request and data (accepted when not full, or
//                   when full but popping in the same cycle)
//   pop             dequeue request (ignored when empty)
//   dout            head entry
//   full, empty     occupancy flags
//   count           occupancy, 0..DEPTH
module trace_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wrPtr, rdPtr;
  logic          popOk, pushOk;

  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));
  assign popOk  = pop & ~empty;
  // A pop frees the slot the push needs, so full+pop still accepts the push.
  assign pushOk = push & (~full | popOk);

  always_ff @(posedge clk) begin
    if (pushOk) mem[wrPtr] <= din;
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (pushOk) wrPtr <= wrPtr + AW'(1);
      if (popOk)  rdPtr <= rdPtr + AW'(1);
      count <= count + CW'(pushOk) - CW'(popOk);
    end
  end

  assign dout = empty ? '0 : mem[rdPtr];

endmodule

// File: rtl/regwrite_trace.sv
// regwrite_trace
// Write-back trace buffer. Every register write to a non-zero register updates
// a shadow register file and is queued as a sequence-numbered record that a
// valid/ready sink drains. Records are lossless until the FIFO is full; beyond
// that they are dropped (the sequence number still advances so the sink can
// see the gap) and a sticky overflow flag is raised.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   wr_valid, wr_addr, wr_data       processor register-write port
//   trace_valid, trace_ready         head record handshake
//   trace_seq, trace_addr, trace_data  head record fields
//   count                            FIFO occupancy
//   overflow, clr_overflow           sticky drop flag and its clear
//   rd_addr, rd_data                 combinational shadow file read (r0 = 0)
//   drop_count                       saturating drop counter
// Build option: define REGWRITE_TRACE_DROPCNT_EN to implement drop_count;
// otherwise drop_count is tied to zero.
module regwrite_trace
  import regwrite_trace_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int SEQ_W  = DEF_SEQ_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_valid,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     trace_valid,
  input  logic                     trace_ready,
  output logic [SEQ_W-1:0]         trace_seq,
  output logic [ADDR_W-1:0]        trace_addr,
  output logic [DATA_W-1:0]        trace_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     clr_overflow,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic [DATA_W-1:0]        rd_data,
  output logic [7:0]               drop_count
);

  typedef struct packed {
    logic [SEQ_W-1:0]  seq;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } rec_t;

  localparam int NREG = 2 ** ADDR_W;

  logic             qual, pop, drop, full, empty;
  logic [SEQ_W-1:0] seq;
  rec_t             newRec, headRec;
  logic [DATA_W-1:0] shadow [NREG];

  // Writes to r0 are architecturally invisible and leave no trace at all.
  assign qual = wr_valid & (wr_addr != '0);
  assign pop  = trace_valid & trace_ready;
  assign drop = qual & full & ~pop;

  assign newRec = '{seq: seq, addr: wr_addr, data: wr_data};

  trace_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(rec_t))
  ) uFifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (qual),
    .pop   (pop),
    .din   (newRec),
    .dout  (headRec),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign trace_valid = ~empty;
  assign trace_seq   = headRec.seq;
  assign trace_addr  = headRec.addr;
  assign trace_data  = headRec.data;

  // Sequence advances on every qualified write, dropped or not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) seq <= '0;
    else if (qual) seq <= seq + SEQ_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) shadow[i] <= '0;
    end else if (qual) begin
      shadow[wr_addr] <= wr_data;
    end
  end

  // No bypass: a read in the write cycle sees the old value.
  assign rd_data = (rd_addr == '0) ? '0 : shadow[rd_addr];

  // A drop in the same cycle as the clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overflow <= 1'b0;
    else if (drop) overflow <= 1'b1;
    else if (clr_overflow) overflow <= 1'b0;
  end

`ifdef REGWRITE_TRACE_DROPCNT_EN
  logic [7:0] dropCnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dropCnt <= '0;
    end else if (drop) begin
      if (clr_overflow)            dropCnt <= 8'd1;
      else if (dropCnt != 8'hFF)   dropCnt <= dropCnt + 8'd1;
    end else if (clr_overflow) begin
      dropCnt <= '0;
    end
  end

  assign drop_count = dropCnt;
`else
  assign drop_count = '0;
`endif

endmodule
